// File: rtl/demux_pkg.sv
// Shared types and constants for the 2x4 demux channel scheduler.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_next_chan.sv
// Circular priority search: first set mask bit after cur, with cur itself last.
module rr_next_chan
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              wrap,
  output logic              none
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    next  = cur;
    found = 1'b0;
    idx   = cur;
    none  = (mask == '0);
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        found = 1'b1;
        next  = idx;
      end
    end
    wrap = found && (next <= cur);
  end

endmodule

// File: rtl/demux_channel_scheduler.sv
// Round-robin burst scheduler feeding the combinational 2x4 demux with
// registered data/select so the demux never sees select glitches.
module demux_channel_scheduler
  import demux_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [WIDTH-1:0]  dout,
  output logic [SEL_W-1:0]  sel,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int              CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t            state;
  logic [SEL_W-1:0]  cur_chan;
  logic [CNT_W-1:0]  burst_cnt;

  logic [SEL_W-1:0]  search_cur;
  logic [SEL_W-1:0]  next_chan;
  logic              wrap;
  logic              none;
  logic              accept;
  logic              go_on;

  // From IDLE, searching after channel 3 yields the lowest set bit.
  assign search_cur = (state == IDLE) ? SEL_W'(NUM_CH - 1) : cur_chan;

  rr_next_chan u_rr (
    .mask (chan_mask),
    .cur  (search_cur),
    .next (next_chan),
    .wrap (wrap),
    .none (none)
  );

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign accept   = in_ready & in_valid;
  assign go_on    = enable & ~none;

  // NOTE: all state here is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_chan   <= '0;
      burst_cnt  <= '0;
      dout       <= '0;
      sel        <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= accept;
      dout       <= accept ? in_data : '0;
      frame_done <= accept && (burst_cnt == LAST) && wrap;
      if (accept) begin
        sel <= cur_chan;
      end

      case (state)
        IDLE: begin
          if (go_on) begin
            state     <= RUN;
            cur_chan  <= next_chan;
            burst_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (burst_cnt == LAST) begin
              burst_cnt <= '0;
              if (go_on) begin
                cur_chan <= next_chan;
              end else begin
                state <= IDLE;
              end
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end else if ((burst_cnt == '0) && !go_on) begin
            // Idle boundary with nothing enabled: release the demux.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_channel_scheduler.sv
// Scoreboard bench: three schedulers (BURST_LEN 4, 2, 1) share one stimulus
// stream; a word-level reference model predicts every routed word.
module tb_demux_channel_scheduler;

  localparam int W  = 8;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [3:0]   chan_mask = 4'b0000;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready_w   [NI];
  logic [W-1:0] dout_w       [NI];
  logic [1:0]   sel_w        [NI];
  logic         dout_valid_w [NI];
  logic         frame_done_w [NI];
  logic         busy_w       [NI];

  demux_channel_scheduler #(.WIDTH(W), .BURST_LEN(4)) u_bl4 (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[0]),
    .dout(dout_w[0]), .sel(sel_w[0]), .dout_valid(dout_valid_w[0]),
    .frame_done(frame_done_w[0]), .busy(busy_w[0]));

  demux_channel_scheduler #(.WIDTH(W), .BURST_LEN(2)) u_bl2 (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[1]),
    .dout(dout_w[1]), .sel(sel_w[1]), .dout_valid(dout_valid_w[1]),
    .frame_done(frame_done_w[1]), .busy(busy_w[1]));

  demux_channel_scheduler #(.WIDTH(W), .BURST_LEN(1)) u_bl1 (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[2]),
    .dout(dout_w[2]), .sel(sel_w[2]), .dout_valid(dout_valid_w[2]),
    .frame_done(frame_done_w[2]), .busy(busy_w[2]));

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int data;
    int sel;
    bit frame;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: running flag, current channel, words sent in this burst.
  bit run      [NI];
  int ch       [NI];
  int sent     [NI];
  int last_sel [NI];

  function automatic int bl_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int lowest_bit(input logic [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return c;
    return -1;
  endfunction

  function automatic int after(input int cur, input logic [3:0] m);
    for (int i = 1; i <= 4; i++) if (m[(cur + i) % 4]) return (cur + i) % 4;
    return -1;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [bl=%0d] t=%0t: got %0d, expected %0d", name, bl_of(k), $time, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NI; k++) begin
      run[k] = 0; ch[k] = 0; sent[k] = 0; last_sel[k] = 0;
    end
    sb.delete();
  endtask

  // Applies the rules to the inputs that were stable across the edge just taken.
  task automatic model_edge();
    int  nxt;
    bit  frame;
    bit  go;
    exp_t e;
    if (rst) return;
    go = enable && (chan_mask != 4'b0000);
    for (int k = 0; k < NI; k++) begin
      if (!run[k]) begin
        if (go) begin
          run[k] = 1; ch[k] = lowest_bit(chan_mask); sent[k] = 0;
        end
      end else if (in_valid) begin
        frame = 0;
        sent[k]++;
        if (sent[k] == bl_of(k)) begin
          sent[k] = 0;
          nxt = after(ch[k], chan_mask);
          frame = (nxt >= 0) && (nxt <= ch[k]);
        end
        e.k = k; e.data = int'(in_data); e.sel = ch[k]; e.frame = frame;
        sb.push_back(e);
        last_sel[k] = ch[k];
        if (sent[k] == 0) begin
          if (go) ch[k] = after(ch[k], chan_mask);
          else    run[k] = 0;
        end
      end else if (sent[k] == 0 && !go) begin
        run[k] = 0;
      end
    end
  endtask

  // Drive one cycle's inputs, take the edge, then update the model.
  task automatic cyc(input bit en, input logic [3:0] m, input bit v, input logic [W-1:0] d);
    enable = en; chan_mask = m; in_valid = v; in_data = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    reset_model();
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready",   k, in_ready_w[k],   0);
      check("rst_dout",       k, dout_w[k],       0);
      check("rst_sel",        k, sel_w[k],        0);
      check("rst_dout_valid", k, dout_valid_w[k], 0);
      check("rst_frame_done", k, frame_done_w[k], 0);
      check("rst_busy",       k, busy_w[k],       0);
    end
    cyc(0, 4'b0000, 0, '0);
    rst = 1'b0;
  endtask

  // Monitor: every cycle, compare each instance against the model/scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].k == k) idx = i;
        end
        check("in_ready",   k, in_ready_w[k],   run[k]);
        check("busy",       k, busy_w[k],       run[k]);
        check("dout_valid", k, dout_valid_w[k], (idx >= 0));
        if (idx >= 0) begin
          if (dout_valid_w[k]) begin
            check("dout",       k, dout_w[k],       sb[idx].data);
            check("sel",        k, sel_w[k],        sb[idx].sel);
            check("frame_done", k, frame_done_w[k], sb[idx].frame);
          end
          sb.delete(idx);
        end else begin
          check("idle_dout",  k, dout_w[k],       0);
          check("idle_frame", k, frame_done_w[k], 0);
          check("sel_hold",   k, sel_w[k],        last_sel[k]);
        end
      end
    end
  end

  initial begin
    reset_model();
    cyc(0, 4'b0000, 0, '0);
    cyc(0, 4'b0000, 0, '0);
    rst = 1'b0;

    // Reset mid-burst, then restart from channel 0.
    cyc(1, 4'b1111, 0, '0);
    cyc(1, 4'b1111, 1, 8'hA1);
    cyc(1, 4'b1111, 1, 8'hA2);
    async_reset();
    cyc(1, 4'b1111, 0, '0);
    for (int i = 0; i < 5; i++) cyc(1, 4'b1111, 1, W'(8'hB0 + i));

    // Full rotation of 16 back-to-back words.
    async_reset();
    cyc(1, 4'b1111, 0, '0);
    for (int i = 0; i < 16; i++) cyc(1, 4'b1111, 1, W'(i));
    cyc(1, 4'b1111, 0, '0);

    // Masked skip over channels 0 and 2.
    async_reset();
    cyc(1, 4'b1010, 0, '0);
    for (int i = 0; i < 8; i++) cyc(1, 4'b1010, 1, W'(8'h40 + i));
    cyc(1, 4'b1010, 0, '0);

    // Mask and enable dropped mid-burst.
    async_reset();
    cyc(1, 4'b0001, 0, '0);
    cyc(1, 4'b0001, 1, 8'h11);
    cyc(1, 4'b0001, 1, 8'h12);
    cyc(0, 4'b0000, 1, 8'h13);
    cyc(0, 4'b0000, 1, 8'h14);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 1, W'(8'h20 + i));

    // Single channel with in_valid gaps.
    async_reset();
    cyc(1, 4'b0100, 0, '0);
    cyc(1, 4'b0100, 1, 8'h31);
    cyc(1, 4'b0100, 0, 8'h32);
    cyc(1, 4'b0100, 1, 8'h33);
    cyc(1, 4'b0100, 1, 8'h34);
    cyc(1, 4'b0100, 0, 8'h35);

    // Start gating on an empty mask.
    async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 4'b0000, 1, W'(8'h50 + i));
    cyc(1, 4'b1000, 1, 8'h60);
    for (int i = 0; i < 4; i++) cyc(1, 4'b1000, 1, W'(8'h61 + i));

    // Randomized traffic, mask churn and occasional resets.
    async_reset();
    begin
      logic [3:0] m;
      m = 4'b1111;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 5) == 0) m = 4'($urandom);
        if ($urandom_range(0, 199) == 0) async_reset();
        else cyc(($urandom_range(0, 7) != 0), m, ($urandom_range(0, 3) != 0), W'($urandom));
      end
    end
    cyc(0, 4'b0000, 0, '0);
    cyc(0, 4'b0000, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
